// File: rtl/fp32_divider_seq_if.sv
// Operand/result bundle for the sequential FP32 divider.
// The master side issues operands and start; the slave side is the divider.
interface fp32_divider_seq_if;
  logic [31:0] X;
  logic [31:0] Y;
  logic        start;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        underflow;
  logic        overflow;
  logic        nan;

  modport master (
    output X, Y, start,
    input  ready, done, result, zero, underflow, overflow, nan
  );

  modport slave (
    input  X, Y, start,
    output ready, done, result, zero, underflow, overflow, nan
  );
endinterface

// File: rtl/fp32_divider_seq.sv
// Sequential IEEE-754 single-precision divider (X / Y), truncating.
// Mantissa quotient comes from a restoring divider producing one bit per
// clock. Denormals are treated as invalid operands. The first quotient bit
// is resolved on the PREP->DIV edge so the DIV state holds the remaining
// bits; done then lands 27 edges after acceptance (2 for special cases).
module fp32_divider_seq #(
  parameter int QBITS = 25
) (
  input  logic               clk,
  input  logic               reset,
  fp32_divider_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_NORM,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'(QBITS - 1);

  state_t              state_q, state_d;

  // Working registers: no reset needed, always rewritten before use.
  logic [31:0]         x_q, y_q;
  logic [24:0]         rem_q;
  logic [24:0]         q_q;
  logic [4:0]          cnt_q;
  logic                sign_q;
  logic signed [9:0]   exp_q;

  // Visible result state: cleared by reset.
  logic [31:0]         result_q;
  logic [3:0]          flags_q;   // {zero, underflow, overflow, nan}
  logic                done_q;

  // Operand classification on the latched operands.
  logic                x_zero, x_inv, y_zero, y_inv, special;
  logic [23:0]         mx, my;
  logic signed [9:0]   exp_calc;
  logic [31:0]         spec_res;
  logic [3:0]          spec_flags;
  logic [24:0]         step_in;
  logic [25:0]         step;
  logic signed [9:0]   exp_adj;
  logic [22:0]         mant;
  logic [35:0]         norm_pack;

  // One restoring step: returns {quotient bit, next remainder}.
  function automatic logic [25:0] div_step(input logic [24:0] rem,
                                           input logic [23:0] d);
    logic [24:0] r;
    logic        ge;
    ge = (rem >= {1'b0, d});
    r  = ge ? (rem - {1'b0, d}) : rem;
    return {ge, r[23:0], 1'b0};
  endfunction

  // Exponent range saturation: returns {flags, packed result}.
  function automatic logic [35:0] range_pack(input logic              s,
                                             input logic signed [9:0] e,
                                             input logic [22:0]       m);
    if (e >= 10'sd255)
      return {4'b0010, s, 8'hFF, 23'b0};
    else if (e <= 10'sd0)
      return {4'b0100, s, 30'b0, 1'b1};
    else
      return {4'b0000, s, e[7:0], m};
  endfunction

  assign x_zero  = (x_q[30:23] == 8'h00) && (x_q[22:0] == 23'b0);
  assign y_zero  = (y_q[30:23] == 8'h00) && (y_q[22:0] == 23'b0);
  assign x_inv   = (x_q[30:23] == 8'hFF) || ((x_q[30:23] == 8'h00) && (x_q[22:0] != 23'b0));
  assign y_inv   = (y_q[30:23] == 8'hFF) || ((y_q[30:23] == 8'h00) && (y_q[22:0] != 23'b0));
  assign special = x_zero || x_inv || y_zero || y_inv;

  assign mx       = {1'b1, x_q[22:0]};
  assign my       = {1'b1, y_q[22:0]};
  assign exp_calc = $signed({2'b00, x_q[30:23]}) - $signed({2'b00, y_q[30:23]}) + 10'sd127;

  assign step_in  = (state_q == S_PREP) ? {1'b0, mx} : rem_q;
  assign step     = div_step(step_in, my);

  assign exp_adj   = q_q[24] ? exp_q : (exp_q - 10'sd1);
  assign mant      = q_q[24] ? q_q[23:1] : q_q[22:0];
  assign norm_pack = range_pack(sign_q, exp_adj, mant);

  // Special-case result by priority: X zero, then invalid, then Y zero.
  always_comb begin
    spec_res   = 32'h0000_0000;
    spec_flags = 4'b0000;
    if (x_zero) begin
      spec_flags = 4'b1000;
    end else if (x_inv || y_inv) begin
      spec_res   = 32'h7F80_0000;
      spec_flags = 4'b0001;
    end else if (y_zero) begin
      spec_res   = {x_q[31] ^ y_q[31], 8'hFF, 23'b0};
      spec_flags = 4'b0010;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start only matters when ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_PREP;
      S_PREP:         state_d = special ? S_DONE : S_DIV;
      S_DIV:          if (cnt_q == LAST_BIT) state_d = S_NORM;
      S_NORM:         state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Operand capture and iterative quotient datapath.
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          x_q <= bus.X;
          y_q <= bus.Y;
        end
      end
      S_PREP: begin
        sign_q <= x_q[31] ^ y_q[31];
        exp_q  <= exp_calc;
        q_q    <= {24'b0, step[25]};
        rem_q  <= step[24:0];
        cnt_q  <= 5'd1;
      end
      S_DIV: begin
        q_q   <= {q_q[23:0], step[25]};
        rem_q <= step[24:0];
        cnt_q <= cnt_q + 5'd1;
      end
      default: ;
    endcase
  end

  // Result/flag registers and the one-cycle done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= 32'h0000_0000;
      flags_q  <= 4'b0000;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_PREP && special) begin
        result_q <= spec_res;
        flags_q  <= spec_flags;
        done_q   <= 1'b1;
      end else if (state_q == S_NORM) begin
        result_q <= norm_pack[31:0];
        flags_q  <= norm_pack[35:32];
        done_q   <= 1'b1;
      end
    end
  end

  assign bus.ready     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.zero      = flags_q[3];
  assign bus.underflow = flags_q[2];
  assign bus.overflow  = flags_q[1];
  assign bus.nan       = flags_q[0];

endmodule

// File: tb/tb_fp32_divider_seq.sv
// Directed bench for the sequential FP32 divider.
module tb_fp32_divider_seq;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  fp32_divider_seq_if bus ();

  fp32_divider_seq #(.QBITS(25)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int LAT_NORM = 27;
  localparam int LAT_SPEC = 2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'b0, bus.zero, bus.underflow, bus.overflow, bus.nan};
  endfunction

  // Issue one operation and wait for done. Latency is the index of the
  // edge (counting the accept edge as 0) at which a consumer would first
  // capture done=1, i.e. one more than the edge after which it rose.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] res, input logic [3:0] fl, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    bus.X = x; bus.Y = y; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, {31'b0, bus.ready}, 32'd0);
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n + 1), 32'(lat));
    chk({tag, "_res"}, bus.result, res);
    chk({tag, "_flg"}, flags(), {28'b0, fl});
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'b0, bus.done}, 32'd0);
    chk({tag, "_hold"}, bus.result, res);
    chk({tag, "_rdy"}, {31'b0, bus.ready}, 32'd1);
  endtask

  initial begin
    int n;
    int dones;
    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.X = 32'h0;
    bus.Y = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", {31'b0, bus.ready}, 32'd1);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_res", bus.result, 32'h0);
    chk("rst_flg", flags(), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    //         tag      X             Y             result        {z,u,o,n}
    run_op("d171",  32'h432B0000, 32'h41180000, 32'h41900000, 4'b0000, LAT_NORM);
    run_op("d150",  32'h43160000, 32'h40400000, 32'h42480000, 4'b0000, LAT_NORM);
    run_op("third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, LAT_NORM);
    run_op("xzero", 32'h80000000, 32'hFFF7FFFF, 32'h00000000, 4'b1000, LAT_SPEC);
    run_op("xnan",  32'h7F880FC0, 32'h3F800000, 32'h7F800000, 4'b0001, LAT_SPEC);
    run_op("ydnrm", 32'h3F800000, 32'h00000001, 32'h7F800000, 4'b0001, LAT_SPEC);
    run_op("ovf",   32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, LAT_NORM);
    run_op("divz",  32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, LAT_SPEC);
    run_op("ndivz", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0010, LAT_SPEC);
    run_op("unf",   32'h00800000, 32'h7F000000, 32'h00000001, 4'b0100, LAT_NORM);
    run_op("nunf",  32'h80800000, 32'h7F000000, 32'h80000001, 4'b0100, LAT_NORM);

    // Start re-pulsed mid-division with different operands is ignored.
    @(negedge clk);
    bus.X = 32'h432B0000; bus.Y = 32'h41180000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    repeat (9) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    bus.X = 32'h3F800000; bus.Y = 32'h40400000; bus.start = 1'b1;
    @(posedge clk); #1;
    n++;
    bus.start = 1'b0;
    bus.X = 32'h7F880FC0; bus.Y = 32'h00000000;
    chk("ign_hold", bus.result, 32'h80000001);
    while (!bus.done && n < 40) begin @(posedge clk); #1; n++; end
    chk("ign_lat", 32'(n + 1), 32'(LAT_NORM));
    chk("ign_res", bus.result, 32'h41900000);
    chk("ign_flg", flags(), 32'h0);

    // Reset in the middle of a division discards it.
    @(negedge clk);
    bus.X = 32'h7F000000; bus.Y = 32'h00800000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mrst_rdy", {31'b0, bus.ready}, 32'd1);
    chk("mrst_res", bus.result, 32'h0);
    chk("mrst_flg", flags(), 32'h0);
    chk("mrst_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("mrst_nodone", 32'(dones), 32'd0);
    chk("mrst_res2", bus.result, 32'h0);

    run_op("post",  32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, LAT_NORM);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
